// File: rtl/fnd_scan_decoder.sv
// Receive-side monitor for the 4-digit multiplexed FND bus: deglitches scan slots, decodes segments to BCD, reports frames.
// Optional FND_DP_CAPTURE_EN adds dp_out[3:0] carrying each slot's decimal point alongside bcd.
module fnd_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  fnd_com,
  input  logic [7:0]  fnd_data,
  output logic [15:0] bcd,
  output logic [13:0] value,
  output logic        frame_valid,
  output logic        changed,
  output logic        err
`ifdef FND_DP_CAPTURE_EN
  ,
  output logic [3:0]  dp_out
`endif
);

  localparam int unsigned COM_W = 4;
  localparam int unsigned SEG_W = 8;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned BCD_W = 16;
  localparam int unsigned VAL_W = 14;
  localparam logic [CNT_W-1:0] ACC_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [COM_W-1:0] r_com, p_com;
  logic [SEG_W-1:0] r_data, p_data;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             same_c, accept_c;
  logic [BCD_W-1:0] slots, slots_nxt;
  logic [3:0]       seen, seen_nxt, seen_set;
  logic [3:0]       sel_c;
  logic             one_hot_c, err_nxt, pending, pending_nxt;
  logic [4:0]       dec_c;
  logic [VAL_W-1:0] value_c, prev_value;
  logic [3:0]       dp_slots, dp_slots_nxt;

  // Returns {valid, digit}; dp (bit7) is forced high before matching.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case ({1'b1, seg})
      8'hC0:   seg_decode = {1'b1, 4'd0};
      8'hF9:   seg_decode = {1'b1, 4'd1};
      8'hA4:   seg_decode = {1'b1, 4'd2};
      8'hB0:   seg_decode = {1'b1, 4'd3};
      8'h99:   seg_decode = {1'b1, 4'd4};
      8'h92:   seg_decode = {1'b1, 4'd5};
      8'h82:   seg_decode = {1'b1, 4'd6};
      8'hF8:   seg_decode = {1'b1, 4'd7};
      8'h80:   seg_decode = {1'b1, 4'd8};
      8'h90:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = 5'd0;
    endcase
  endfunction

  // Stability counter: restart on any change of the registered bus, else saturate upward.
  assign same_c   = ({r_com, r_data} == {p_com, p_data});
  assign cnt_nxt  = !same_c ? '0 : ((cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1));
  assign accept_c = (cnt_nxt == ACC_CNT);

  assign sel_c     = ~r_com;
  assign one_hot_c = (sel_c != 4'd0) && ((sel_c & (sel_c - 4'd1)) == 4'd0);
  assign dec_c     = seg_decode(r_data[6:0]);

  assign value_c = VAL_W'(slots[15:12]) * VAL_W'(1000) + VAL_W'(slots[11:8]) * VAL_W'(100)
                 + VAL_W'(slots[7:4]) * VAL_W'(10) + VAL_W'(slots[3:0]);

  // Slot assembly and error classification on each accept strobe.
  always_comb begin
    slots_nxt    = slots;
    dp_slots_nxt = dp_slots;
    seen_nxt     = seen;
    seen_set     = seen | sel_c;
    err_nxt      = err;
    pending_nxt  = 1'b0;
    if (accept_c && (r_com != 4'hF)) begin
      if (one_hot_c && dec_c[4]) begin
        for (int i = 0; i < 4; i++) begin
          if (sel_c[i]) begin
            slots_nxt[i*DIG_W +: DIG_W] = dec_c[3:0];
            dp_slots_nxt[i]             = ~r_data[7];
          end
        end
        if (seen_set == 4'hF) begin
          seen_nxt    = 4'd0;
          pending_nxt = 1'b1;
        end else begin
          seen_nxt = seen_set;
        end
      end else begin
        err_nxt  = 1'b1;
        seen_nxt = 4'd0;
      end
    end
  end

  // Idle-bus reset value keeps a reset-time sample from ever classifying as multi-hot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_com    <= 4'hF;
      r_data   <= 8'hFF;
      p_com    <= 4'hF;
      p_data   <= 8'hFF;
      cnt      <= '0;
      slots    <= '0;
      dp_slots <= '0;
      seen     <= '0;
      err      <= 1'b0;
      pending  <= 1'b0;
    end else begin
      r_com    <= fnd_com;
      r_data   <= fnd_data;
      p_com    <= r_com;
      p_data   <= r_data;
      cnt      <= cnt_nxt;
      slots    <= slots_nxt;
      dp_slots <= dp_slots_nxt;
      seen     <= seen_nxt;
      err      <= err_nxt;
      pending  <= pending_nxt;
    end
  end

  // Publish a completed frame one cycle after its final accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd         <= '0;
      value       <= '0;
      prev_value  <= '0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
`ifdef FND_DP_CAPTURE_EN
      dp_out      <= '0;
`endif
    end else if (pending) begin
      bcd         <= slots;
      value       <= value_c;
      prev_value  <= value_c;
      frame_valid <= 1'b1;
      changed     <= (value_c != prev_value);
`ifdef FND_DP_CAPTURE_EN
      dp_out      <= dp_slots;
`endif
    end else begin
      frame_valid <= 1'b0;
      changed     <= 1'b0;
    end
  end

endmodule
